// File: rtl/circ_437_pkg.sv
// Shared definitions for the circ_437 adder/subtractor and its accumulator controller.
package circ_437_pkg;

  localparam int unsigned WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MUL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  // Borrow-ripple decrement; keeps the adder free for the datapath during MUL.
  function automatic logic [WIDTH-1:0] dec(input logic [WIDTH-1:0] v);
    logic             borrow;
    logic [WIDTH-1:0] r;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      r[i]   = v[i] ^ borrow;
      borrow = borrow & ~v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/circ_437.sv
// 4-bit adder/subtractor: M=0 gives A+B, M=1 gives A+~B+1 (Cout=1 means no borrow).
module circ_437 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       M,
  output logic [3:0] S,
  output logic       Cout
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  assign b_eff   = B ^ {4{M}};
  assign sum     = {1'b0, A} + {1'b0, b_eff} + {4'b0000, M};
  assign S       = sum[3:0];
  assign Cout    = sum[4];

endmodule

// File: rtl/acc_seq_437.sv
// Accumulator controller around circ_437: LOAD/ADD/SUB and repeated-addition MUL
// under a start/ready/done handshake.
module acc_seq_437 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  import circ_437_pkg::*;

  state_e           state_q;
  op_e              op_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ready_q;
  logic             done_q;

  logic [WIDTH-1:0] add_b;
  logic             add_m;
  logic [WIDTH-1:0] add_s;
  logic             add_c;

  // Adder always driven from registered operands; only consumed in StExec.
  assign add_b = (op_q == OP_MUL) ? mcand_q : din_q;
  assign add_m = (op_q == OP_SUB);

  circ_437 u_adder (
    .A    (acc_q),
    .B    (add_b),
    .M    (add_m),
    .S    (add_s),
    .Cout (add_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OP_LOAD;
      din_q   <= '0;
      count_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op_e'(op);
            din_q   <= din;
            state_q <= StExec;
            ready_q <= 1'b0;
            if (op == OP_MUL) begin
              mcand_q <= acc_q;
              count_q <= din;
              acc_q   <= '0;
              cout_q  <= 1'b0;
            end
          end
        end
        StExec: begin
          state_q <= StDone;
          done_q  <= 1'b1;
          unique case (op_q)
            OP_LOAD: begin
              acc_q  <= din_q;
              cout_q <= 1'b0;
              ovf_q  <= 1'b0;
            end
            OP_ADD: begin
              acc_q  <= add_s;
              cout_q <= add_c;
              ovf_q  <= (acc_q[WIDTH-1] == din_q[WIDTH-1]) &&
                        (add_s[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
              acc_q  <= add_s;
              cout_q <= add_c;
              ovf_q  <= (acc_q[WIDTH-1] != din_q[WIDTH-1]) &&
                        (add_s[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_MUL: begin
              if (count_q != '0) begin
                acc_q   <= add_s;
                cout_q  <= cout_q | add_c;
                count_q <= dec(count_q);
                if (count_q != WIDTH'(1)) begin
                  state_q <= StExec;
                  done_q  <= 1'b0;
                end else begin
                  ovf_q <= cout_q | add_c;
                end
              end else begin
                ovf_q <= cout_q;
              end
            end
            default: ;
          endcase
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign acc   = acc_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign zero  = (acc_q == '0);

endmodule

// File: tb/tb_acc_seq_437.sv
// Scoreboard bench for acc_seq_437: directed commands push expectations, a monitor
// pops and compares on every done pulse.
module tb_acc_seq_437;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] din;
  logic       ready, done, cout, ovf, zero;
  logic [3:0] acc;

  acc_seq_437 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .din   (din),
    .ready (ready),
    .done  (done),
    .acc   (acc),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [3:0] acc;
    logic       cout;
    logic       ovf;
    logic       zero;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  int   next_id = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else passed++;
  endtask

  // Monitor: every done pulse must match the oldest outstanding command.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("t%0d_acc", e.id), 32'(acc), 32'(e.acc));
          chk($sformatf("t%0d_cout", e.id), 32'(cout), 32'(e.cout));
          chk($sformatf("t%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
          chk($sformatf("t%0d_zero", e.id), 32'(zero), 32'(e.zero));
          chk($sformatf("t%0d_latency", e.id), 32'(cyc - e.start_cyc + 1), 32'(e.lat));
        end
      end
    end
  end

  // Issue one command at a negedge; hold=1 keeps start high with junk operands during EXEC.
  task automatic issue(input logic [1:0] o, input logic [3:0] d, input logic [3:0] eacc,
                       input logic ec, input logic eo, input int elat, input bit hold);
    exp_t e;
    int   n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", 32'(ready), 32'd1);
    start = 1'b1;
    op    = o;
    din   = d;
    @(posedge clk);
    #1;
    e.id        = next_id++;
    e.acc       = eacc;
    e.cout      = ec;
    e.ovf       = eo;
    e.zero      = (eacc == 4'd0);
    e.lat       = elat;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    if (hold) begin
      op  = 2'b00;
      din = 4'd2;
      @(negedge clk);
      din = 4'd9;
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      chk("done_timeout", 32'(done), 32'd1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : stimulus
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    din   = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(acc), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //    op     din    acc    c     o     lat hold
    issue(2'b00, 4'd4,  4'd4,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b01, 4'd4,  4'd8,  1'b0, 1'b1, 2, 1'b0);
    issue(2'b00, 4'd4,  4'd4,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b10, 4'd4,  4'd0,  1'b1, 1'b0, 2, 1'b0);
    issue(2'b00, 4'd4,  4'd4,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b10, 4'd5,  4'd15, 1'b0, 1'b0, 2, 1'b0);
    issue(2'b00, 4'd7,  4'd7,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b01, 4'd8,  4'd15, 1'b0, 1'b0, 2, 1'b0);
    issue(2'b00, 4'd15, 4'd15, 1'b0, 1'b0, 2, 1'b0);
    issue(2'b01, 4'd1,  4'd0,  1'b1, 1'b0, 2, 1'b0);
    issue(2'b00, 4'd3,  4'd3,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b11, 4'd5,  4'd15, 1'b0, 1'b0, 6, 1'b0);
    issue(2'b00, 4'd7,  4'd7,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b11, 4'd3,  4'd5,  1'b1, 1'b1, 4, 1'b0);
    issue(2'b00, 4'd9,  4'd9,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b11, 4'd0,  4'd0,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b00, 4'd3,  4'd3,  1'b0, 1'b0, 2, 1'b0);
    issue(2'b11, 4'd5,  4'd15, 1'b0, 1'b0, 6, 1'b1);
    issue(2'b00, 4'd3,  4'd3,  1'b0, 1'b0, 2, 1'b0);

    // Abort a MUL (3*7) with asynchronous reset partway through.
    start = 1'b1;
    op    = 2'b11;
    din   = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_acc", 32'(acc), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    issue(2'b00, 4'd6, 4'd6, 1'b0, 1'b0, 2, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_seq_437.md
Name: acc_seq_437

Overview:
- Sequential accumulator controller that drives the 4-bit adder/subtractor `circ_437` (ports A, B, M in; S, Cout out).
- Holds a 4-bit accumulator as operand A and takes operand B from `din`. Executes LOAD/ADD/SUB/MUL commands under a start/ready/done handshake.
- Sits directly upstream of `circ_437` and also consumes its outputs: the adder's S and Cout are registered back into the accumulator and the flags.

Parameters:
- WIDTH, 4, datapath width. Fixed at 4 to match `circ_437`; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  command request; sampled only while ready=1
- op  input  2  command code: 00 LOAD, 01 ADD, 10 SUB, 11 MUL
- din  input  4  operand B, or multiplier for MUL
- ready  output  1  high only in IDLE
- done  output  1  one-cycle pulse when the command completes
- acc  output  4  accumulator register
- cout  output  1  carry flag (registered)
- ovf  output  1  overflow flag (registered)
- zero  output  1  combinational (acc == 0)

Behaviour:
- Reset (async, any state): state=IDLE, acc=0, cout=0, ovf=0, done=0, ready=1, zero=1. Internal op/din/count/multiplicand registers are cleared. Reset mid-command aborts the command with no done pulse.
- FSM states and transitions:
  - IDLE -> EXEC on the edge where start=1. That same edge captures op and din into internal registers; later changes to op/din are ignored.
  - EXEC -> DONE when the operation finishes.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
  - start is ignored in EXEC and DONE, since ready=0 there. Back-to-back throughput is one command per 3 cycles (non-MUL).
- LOAD: one EXEC cycle. acc<=din, cout<=0, ovf<=0.
- ADD: one EXEC cycle. The adder sees A=acc, B=din_r, M=0. acc<=S, cout<=Cout, ovf<=(acc[3]==din_r[3]) && (S[3]!=acc[3]).
- SUB: one EXEC cycle. The adder sees M=1 (two's complement, A+~B+1). acc<=S, cout<=Cout (1 = no borrow), ovf<=(acc[3]!=din_r[3]) && (S[3]!=acc[3]).
- MUL (repeated addition, unsigned, result mod 16):
  - On the start edge: mcand<=acc, count<=din, acc<=0, cout<=0.
  - Each EXEC cycle with count!=0: adder A=acc, B=mcand, M=0; acc<=S; cout<=cout|Cout; count<=count-1.
  - Leave EXEC when count reaches 0.
  - din=0: exactly one EXEC cycle with no update; acc=0, cout=0.
  - ovf<=cout at completion, i.e. ovf = unsigned overflow of the product.
- Latency from the start edge to done=1: 2 cycles for LOAD/ADD/SUB; max(din,1)+1 cycles for MUL.
- Flags and acc change only in EXEC (or the MUL start edge); otherwise they hold.
- Adder inputs are don't-care outside EXEC but must be driven by the registered values; no latches.

Decomposition:
- Shared package `circ_437_pkg`:
  - op codes OP_LOAD=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_MUL=2'b11
  - state encoding IDLE/EXEC/DONE
  - WIDTH=4
- One sub-module: an instance of the existing `circ_437` adder/subtractor. All arithmetic goes through it; no separate `+` or `-` in this block.

Test Plan:
- Reset → acc=0, cout=0, ovf=0, zero=1, ready=1, done=0. Assert rst mid-MUL → same values immediately, asynchronously, with no done pulse.
- LOAD 4, then ADD 4 → acc=8, cout=0, ovf=1, zero=0. done rises exactly 2 cycles after each start edge.
- LOAD 4, SUB 4 → acc=0, cout=1, ovf=0, zero=1. LOAD 4, SUB 5 → acc=15, cout=0, ovf=0.
- LOAD 7, ADD 8 → acc=15, cout=0, ovf=0. LOAD 15, ADD 1 → acc=0, cout=1, ovf=0, zero=1.
- LOAD 3, MUL 5 → acc=15, cout=0, done 6 cycles after start. LOAD 7, MUL 3 → acc=5, cout=1, ovf=1. LOAD 9, MUL 0 → acc=0, cout=0, done after 2 cycles.
- During a MUL, hold start=1 with op=LOAD, din=2 → ignored; acc ends at the MUL result. Change din mid-EXEC → result unchanged, because operands are captured at start.
